// File: rtl/bsk_mgr_cut_sched.sv
// Ring-ordered ownership scheduler for the BSK cut buffer slots (loader -> reader -> free).
// Optional protocol error detection is enabled by defining BSK_MGR_CUT_SCHED_ERR_EN.
module bsk_mgr_cut_sched #(
  parameter  int unsigned BSK_CUT_NB = 16,
  parameter  int unsigned REUSE_W    = 8,
  localparam int unsigned CUT_W      = $clog2(BSK_CUT_NB)
) (
  input  logic               clk,
  input  logic               s_rst,
  input  logic [REUSE_W-1:0] cfg_reuse_nb,
  output logic               ld_slot_vld,
  input  logic               ld_slot_rdy,
  output logic [CUT_W-1:0]   ld_slot_id,
  input  logic               ld_done_vld,
  input  logic [CUT_W-1:0]   ld_done_id,
  output logic               rd_slot_vld,
  input  logic               rd_slot_rdy,
  output logic [CUT_W-1:0]   rd_slot_id,
  input  logic               rd_done,
  input  logic               flush_req,
  output logic               flush_done,
  output logic [CUT_W:0]     occupancy,
  output logic               err
);

  typedef enum logic [1:0] {S_FREE, S_LOADING, S_FULL, S_READING} slot_e;
  typedef enum logic [1:0] {ST_RUN, ST_FLUSH_WAIT, ST_FLUSH} fsm_e;

  fsm_e               r_fsm;
  fsm_e               w_fsm_nxt;
  slot_e              r_slot [BSK_CUT_NB];
  logic [CUT_W-1:0]   r_wr_ptr;
  logic [CUT_W-1:0]   r_rd_ptr;
  logic [REUSE_W-1:0] r_reuse_cnt;
  logic [CUT_W:0]     r_occ;

  logic               w_any_reading;
  logic               w_loading_pending;
  logic               w_ld_hs;
  logic               w_rd_hs;
  logic               w_ld_done_ok;
  logic               w_rd_done_ok;
  logic               w_free;
  logic [REUSE_W-1:0] w_reuse_init;

  assign ld_slot_vld  = (r_fsm == ST_RUN) && (r_slot[r_wr_ptr] == S_FREE);
  assign ld_slot_id   = r_wr_ptr;
  assign rd_slot_vld  = (r_fsm == ST_RUN) && (r_slot[r_rd_ptr] == S_FULL) && !w_any_reading;
  assign rd_slot_id   = r_rd_ptr;
  assign flush_done   = (r_fsm == ST_FLUSH);
  assign occupancy    = r_occ;

  assign w_ld_hs      = ld_slot_vld && ld_slot_rdy;
  assign w_rd_hs      = rd_slot_vld && rd_slot_rdy;
  assign w_ld_done_ok = ld_done_vld && (r_slot[ld_done_id] == S_LOADING);
  // Reads are strictly in ring order, so the READING slot is always the one at r_rd_ptr.
  assign w_rd_done_ok = rd_done && (r_fsm == ST_RUN) && w_any_reading;
  assign w_free       = w_rd_done_ok && (r_reuse_cnt <= REUSE_W'(1));
  assign w_reuse_init = (cfg_reuse_nb == '0) ? REUSE_W'(1) : cfg_reuse_nb;

  always_comb begin
    w_any_reading     = 1'b0;
    w_loading_pending = 1'b0;
    for (int unsigned i = 0; i < BSK_CUT_NB; i++) begin
      if (r_slot[i] == S_READING)
        w_any_reading = 1'b1;
      if ((r_slot[i] == S_LOADING) && !(w_ld_done_ok && (ld_done_id == CUT_W'(i))))
        w_loading_pending = 1'b1;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      ST_RUN:        if (flush_req) w_fsm_nxt = ST_FLUSH_WAIT;
      ST_FLUSH_WAIT: if (!w_loading_pending) w_fsm_nxt = ST_FLUSH;
      ST_FLUSH:      w_fsm_nxt = ST_RUN;
      default:       w_fsm_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      r_fsm       <= ST_RUN;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_reuse_cnt <= '0;
      r_occ       <= '0;
      for (int unsigned i = 0; i < BSK_CUT_NB; i++)
        r_slot[i] <= S_FREE;
    end else begin
      r_fsm <= w_fsm_nxt;
      // State is wiped on entry to FLUSH, so it already reads empty while flush_done is high.
      if (w_fsm_nxt == ST_FLUSH) begin
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_reuse_cnt <= '0;
        r_occ       <= '0;
        for (int unsigned i = 0; i < BSK_CUT_NB; i++)
          r_slot[i] <= S_FREE;
      end else begin
        if (w_ld_hs) begin
          r_slot[r_wr_ptr] <= S_LOADING;
          r_wr_ptr         <= r_wr_ptr + 1'b1;
        end
        if (w_ld_done_ok)
          r_slot[ld_done_id] <= S_FULL;
        if (w_rd_hs) begin
          r_slot[r_rd_ptr] <= S_READING;
          r_reuse_cnt      <= w_reuse_init;
        end
        if (w_rd_done_ok) begin
          if (w_free) begin
            r_slot[r_rd_ptr] <= S_FREE;
            r_rd_ptr         <= r_rd_ptr + 1'b1;
          end else begin
            r_reuse_cnt <= r_reuse_cnt - 1'b1;
          end
        end
        r_occ <= r_occ + (CUT_W+1)'(w_ld_hs) - (CUT_W+1)'(w_free);
      end
    end
  end

`ifdef BSK_MGR_CUT_SCHED_ERR_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (s_rst)
      r_err <= 1'b0;
    else if ((ld_done_vld && !w_ld_done_ok) ||
             (rd_done && (r_fsm == ST_RUN) && !w_any_reading))
      r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bsk_mgr_cut_sched.sv
// Self-checking bench for bsk_mgr_cut_sched: directed scenarios plus random traffic
// against a queue-based ownership model of the slot ring.
module tb_bsk_mgr_cut_sched;

  localparam int N     = 16;
  localparam int CUT_W = 4;

  logic             clk = 1'b0;
  logic             s_rst;
  logic [7:0]       cfg_reuse_nb;
  logic             ld_slot_vld;
  logic             ld_slot_rdy;
  logic [CUT_W-1:0] ld_slot_id;
  logic             ld_done_vld;
  logic [CUT_W-1:0] ld_done_id;
  logic             rd_slot_vld;
  logic             rd_slot_rdy;
  logic [CUT_W-1:0] rd_slot_id;
  logic             rd_done;
  logic             flush_req;
  logic             flush_done;
  logic [CUT_W:0]   occupancy;
  logic             err;

  always #5 clk = ~clk;

  bsk_mgr_cut_sched #(.BSK_CUT_NB(N), .REUSE_W(8)) u_dut (
    .clk(clk), .s_rst(s_rst), .cfg_reuse_nb(cfg_reuse_nb),
    .ld_slot_vld(ld_slot_vld), .ld_slot_rdy(ld_slot_rdy), .ld_slot_id(ld_slot_id),
    .ld_done_vld(ld_done_vld), .ld_done_id(ld_done_id),
    .rd_slot_vld(rd_slot_vld), .rd_slot_rdy(rd_slot_rdy), .rd_slot_id(rd_slot_id),
    .rd_done(rd_done), .flush_req(flush_req), .flush_done(flush_done),
    .occupancy(occupancy), .err(err)
  );

`ifdef BSK_MGR_CUT_SCHED_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Model: owned slots in ring order (front = oldest), per-slot load progress, one active reader.
  int q[$];
  bit m_loading [N];
  bit m_filled  [N];
  bit m_reading;
  int m_left;
  int m_head;
  int m_mode;   // 0 run, 1 waiting for loads to drain, 2 flush cycle
  bit m_err;
  int cand[$];

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit e_ld_vld();
    return (m_mode == 0) && (q.size() < N);
  endfunction

  function automatic bit e_rd_vld();
    return (m_mode == 0) && (q.size() > 0) && m_filled[q[0]] && !m_reading;
  endfunction

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < N; i++) begin
      m_loading[i] = 1'b0;
      m_filled[i]  = 1'b0;
    end
    m_reading = 1'b0;
    m_left    = 0;
    m_head    = 0;
  endtask

  task automatic model_update();
    bit ldhs, rdhs, done_ok, rdd_ok, any_loading;
    int did;
    if (s_rst) begin
      model_clear();
      m_mode = 0;
      m_err  = 1'b0;
      return;
    end
    did     = int'(ld_done_id);
    ldhs    = e_ld_vld() && ld_slot_rdy;
    rdhs    = e_rd_vld() && rd_slot_rdy;
    done_ok = ld_done_vld && m_loading[did];
    rdd_ok  = rd_done && (m_mode == 0) && m_reading;
    if (ERR_EN && ((ld_done_vld && !done_ok) || (rd_done && (m_mode == 0) && !m_reading)))
      m_err = 1'b1;
    if (done_ok) begin
      m_loading[did] = 1'b0;
      m_filled[did]  = 1'b1;
    end
    case (m_mode)
      0: begin
        if (ldhs) begin
          m_loading[(m_head + q.size()) % N] = 1'b1;
          q.push_back((m_head + q.size()) % N);
        end
        if (rdhs) begin
          m_reading = 1'b1;
          m_left    = (cfg_reuse_nb == 0) ? 1 : int'(cfg_reuse_nb);
        end
        if (rdd_ok) begin
          if (m_left == 1) begin
            m_filled[q[0]] = 1'b0;
            void'(q.pop_front());
            m_reading = 1'b0;
            m_head    = (m_head + 1) % N;
          end else begin
            m_left--;
          end
        end
        if (flush_req) m_mode = 1;
      end
      1: begin
        any_loading = 1'b0;
        for (int i = 0; i < N; i++) if (m_loading[i]) any_loading = 1'b1;
        if (!any_loading) begin
          model_clear();
          m_mode = 2;
        end
      end
      default: m_mode = 0;
    endcase
  endtask

  task automatic compare_all();
    chk("ld_slot_vld", int'(ld_slot_vld), int'(e_ld_vld()));
    chk("ld_slot_id",  int'(ld_slot_id),  (m_head + q.size()) % N);
    chk("rd_slot_vld", int'(rd_slot_vld), int'(e_rd_vld()));
    chk("rd_slot_id",  int'(rd_slot_id),  m_head);
    chk("occupancy",   int'(occupancy),   q.size());
    chk("flush_done",  int'(flush_done),  (m_mode == 2) ? 1 : 0);
    chk("err",         int'(err),         int'(m_err));
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    ld_slot_rdy = 1'b0;
    ld_done_vld = 1'b0;
    ld_done_id  = '0;
    rd_slot_rdy = 1'b0;
    rd_done     = 1'b0;
    flush_req   = 1'b0;
  endtask

  task automatic cyc(input bit ldr, input bit dv, input int did, input bit rdr, input bit rdd, input bit fl);
    ld_slot_rdy = ldr;
    ld_done_vld = dv;
    ld_done_id  = CUT_W'(did);
    rd_slot_rdy = rdr;
    rd_done     = rdd;
    flush_req   = fl;
    tick();
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    s_rst = 1'b1;
    tick();
    tick();
    s_rst = 1'b0;
    tick();
  endtask

  initial begin
    idle_inputs();
    cfg_reuse_nb = 8'd1;
    s_rst        = 1'b1;

    // Reset state
    do_reset();
    chk("rst_ld_vld", int'(ld_slot_vld), 1);
    chk("rst_ld_id",  int'(ld_slot_id),  0);
    chk("rst_rd_vld", int'(rd_slot_vld), 0);
    chk("rst_occ",    int'(occupancy),   0);

    // Four cuts, each read twice, in ring order
    cfg_reuse_nb = 8'd2;
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, i, 0, 0, 0);
    chk("s1_occ_peak", int'(occupancy), 4);
    for (int i = 0; i < 4; i++) begin
      chk("s1_rd_id", int'(rd_slot_id), i);
      cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 0);
    end
    chk("s1_occ_end", int'(occupancy),  0);
    chk("s1_wr_ptr",  int'(ld_slot_id), 4);
    chk("s1_rd_ptr",  int'(rd_slot_id), 4);

    // Ring full, then one freed slot re-offered with wrap to 0
    do_reset();
    cfg_reuse_nb = 8'd1;
    for (int i = 0; i < N; i++) cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) cyc(0, 1, i, 0, 0, 0);
    chk("s2_occ_full", int'(occupancy),   16);
    chk("s2_ld_vld0",  int'(ld_slot_vld), 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("s2_ld_vld1", int'(ld_slot_vld), 1);
    chk("s2_ld_wrap", int'(ld_slot_id),  0);

    // Out-of-order load completion; reads stay in ring order
    do_reset();
    cfg_reuse_nb = 8'd0;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 2, 0, 0, 0);
    chk("s3_rd_wait2", int'(rd_slot_vld), 0);
    cyc(0, 1, 1, 0, 0, 0);
    chk("s3_rd_wait1", int'(rd_slot_vld), 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("s3_rd_rise", int'(rd_slot_vld), 1);
    for (int i = 0; i < 3; i++) begin
      chk("s3_rd_id", int'(rd_slot_id), i);
      cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
    end

    // Same-cycle load grant and freeing read keep occupancy flat
    do_reset();
    cfg_reuse_nb = 8'd1;
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, i, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
    end
    cyc(0, 0, 0, 1, 0, 0);
    chk("s4_occ_pre", int'(occupancy),  3);
    chk("s4_ld_id",   int'(ld_slot_id), 5);
    cyc(1, 0, 0, 0, 1, 0);
    chk("s4_occ_post", int'(occupancy), 3);

    // Flush with slots 3,4 loading and slot 1 reading
    do_reset();
    cfg_reuse_nb = 8'd1;
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, i, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("s5_no_ld", int'(ld_slot_vld), 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 1, 3, 0, 0, 0);
    chk("s5_wait", int'(flush_done), 0);
    cyc(0, 1, 4, 0, 0, 0);
    chk("s5_done", int'(flush_done), 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("s5_done_pulse", int'(flush_done),  0);
    chk("s5_occ",        int'(occupancy),   0);
    chk("s5_ld_id",      int'(ld_slot_id),  0);
    chk("s5_ld_vld",     int'(ld_slot_vld), 1);

    // Completion for a FREE slot
    do_reset();
    cyc(0, 1, 7, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("s6_err", int'(err), ERR_EN ? 1 : 0);
    chk("s6_occ", int'(occupancy), 0);

    // Random legal traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      cfg_reuse_nb = 8'($urandom_range(0, 3));
      ld_slot_rdy  = ($urandom_range(0, 9) < 7);
      rd_slot_rdy  = ($urandom_range(0, 9) < 7);
      rd_done      = m_reading && ($urandom_range(0, 1) == 1);
      flush_req    = ($urandom_range(0, 149) == 0);
      ld_done_vld  = 1'b0;
      ld_done_id   = '0;
      if ($urandom_range(0, 9) < 4) begin
        cand.delete();
        for (int i = 0; i < N; i++) if (m_loading[i]) cand.push_back(i);
        if (cand.size() > 0) begin
          ld_done_vld = 1'b1;
          ld_done_id  = CUT_W'(cand[$urandom_range(0, cand.size() - 1)]);
        end
      end
      tick();
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
